// File: rtl/pea_command_scheduler_if.sv
// Handshake bundle between the PEA firing controller and its FIFOs/datapath.
// The master side is the scheduler; the slave side is the FIFO/datapath environment.
interface pea_command_scheduler_if #(
  parameter int word_size = 16,
  parameter int pw        = 10
);
  logic                   invoke;
  logic                   enable_out;
  logic                   done_out;
  logic                   busy;
  logic [word_size-1:0]   command_in;
  logic [pw-1:0]          command_pop;
  logic                   command_rd_en;
  logic [pw-1:0]          data_pop;
  logic [pw-1:0]          result_free_space;
  logic [pw-1:0]          status_free_space;
  logic                   status_wr_en;
  logic [2*word_size-1:0] status_out;
  logic [3:0]             ni_in;
  logic                   dp_start;
  logic [2:0]             dp_op;
  logic [2:0]             dp_a;
  logic [4:0]             dp_b;
  logic                   dp_done;

  modport master (
    input  invoke, command_in, command_pop, data_pop, result_free_space,
           status_free_space, ni_in, dp_done,
    output enable_out, done_out, busy, command_rd_en, status_wr_en, status_out,
           dp_start, dp_op, dp_a, dp_b
  );

  modport slave (
    output invoke, command_in, command_pop, data_pop, result_free_space,
           status_free_space, ni_in, dp_done,
    input  enable_out, done_out, busy, command_rd_en, status_wr_en, status_out,
           dp_start, dp_op, dp_a, dp_b
  );
endinterface

// File: rtl/pea_command_scheduler.sv
// PEA firing controller: pops one command per invoke, validates it, waits for FIFO
// resources (bounded), runs the datapath and writes exactly one status token.
module pea_command_scheduler #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int wait_limit  = 256
) (
  input logic                    clk,
  input logic                    rst,
  pea_command_scheduler_if.master bus
);
  localparam int PW  = $clog2(buffer_size);
  localparam int WCW = (wait_limit > 2) ? $clog2(wait_limit) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_CHECK, S_START, S_BUSY, S_STATUS, S_DONE
  } state_t;

  state_t                 state, state_next;
  logic [word_size-1:0]   cmd_reg;
  logic [WCW-1:0]         wait_cnt;
  logic                   wait_inc;
  logic [7:0]             code_next;
  logic [2*word_size-1:0] status_reg;

  logic [7:0]             op;
  logic [4:0]             arg_b;
  logic [7:0]             err_code;
  logic                   res_ready;
  logic [PW-1:0]          b_pw, b1_pw, ni1_pw;
  logic                   enable;

  assign op     = cmd_reg[15:8];
  assign arg_b  = cmd_reg[4:0];
  assign b_pw   = PW'(arg_b);
  assign b1_pw  = PW'({1'b0, arg_b} + 6'd1);
  assign ni1_pw = PW'({1'b0, bus.ni_in} + 5'd1);
  assign enable = (bus.command_pop != '0) && (bus.status_free_space != '0);

  // Command validation; earlier checks win when several errors apply at once
  always_comb begin
    err_code = 8'h00;
    if (op < 8'h01 || op > 8'h05)
      err_code = 8'h01;
    else if ((op == 8'h02 || op == 8'h03 || op == 8'h04) && bus.ni_in == 4'hF)
      err_code = 8'h02;
    else if ((op == 8'h01 && arg_b > 5'd10) || (op == 8'h03 && arg_b == 5'd0))
      err_code = 8'h03;
  end

  always_comb begin
    res_ready = 1'b0;
    case (op)
      8'h01:   res_ready = bus.data_pop >= b1_pw;
      8'h02:   res_ready = (bus.data_pop >= PW'(1)) && (bus.result_free_space >= PW'(1));
      8'h03:   res_ready = (bus.data_pop >= b_pw) && (bus.result_free_space >= b_pw);
      8'h04:   res_ready = bus.result_free_space >= ni1_pw;
      8'h05:   res_ready = 1'b1;
      default: res_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    code_next  = 8'h00;
    wait_inc   = 1'b0;
    case (state)
      S_IDLE:  if (bus.invoke && enable) state_next = S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_CHECK;
      S_CHECK: begin
        if (err_code != 8'h00) begin
          state_next = S_STATUS;
          code_next  = err_code;
        end else if (res_ready) begin
          state_next = S_START;
        end else if (wait_cnt == WCW'(wait_limit - 1)) begin
          state_next = S_STATUS;
          code_next  = 8'h04;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_START:  state_next = S_BUSY;
      S_BUSY:   if (bus.dp_done) state_next = S_STATUS;
      S_STATUS: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // The status word is loaded on entry to STATUS so it is already valid alongside status_wr_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_reg    <= '0;
      wait_cnt   <= '0;
      status_reg <= '0;
    end else begin
      state <= state_next;
      if (state == S_LATCH) begin
        cmd_reg  <= bus.command_in;
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state_next == S_STATUS && state != S_STATUS)
        status_reg <= {cmd_reg, {(word_size-8){1'b0}}, code_next};
    end
  end

  assign bus.enable_out    = enable;
  assign bus.busy          = (state != S_IDLE);
  assign bus.command_rd_en = (state == S_FETCH);
  assign bus.dp_start      = (state == S_START);
  assign bus.status_wr_en  = (state == S_STATUS);
  assign bus.done_out      = (state == S_DONE);
  assign bus.status_out    = status_reg;
  assign bus.dp_op         = cmd_reg[10:8];
  assign bus.dp_a          = cmd_reg[7:5];
  assign bus.dp_b          = cmd_reg[4:0];
endmodule

// File: tb/tb_pea_command_scheduler.sv
// Bench for pea_command_scheduler: directed scenarios plus randomized firings checked
// against an outcome model derived from the command rules.
module tb_pea_command_scheduler;
  localparam int WS = 16;
  localparam int PW = 10;
  localparam int WL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pea_command_scheduler_if #(.word_size(WS), .pw(PW)) bus ();
  pea_command_scheduler #(.word_size(WS), .buffer_size(1024), .wait_limit(WL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int rd_cnt = 0, start_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [2:0]    start_op, start_a;
  logic [4:0]    start_b;
  logic [PW-1:0] start_dpop;
  logic [31:0]   last_status;
  int s_rd, s_start, s_wr, s_done, s_busy;
  int d_rd, d_start, d_wr, d_done, d_busy;

  logic [15:0] pending_cmd = 16'h0000;
  logic        cmd_hold = 1'b0;
  int          dp_lat = 0;
  logic        dp_auto = 1'b1;
  int          dp_cd = -1;
  logic        auto_done = 1'b0;
  logic        force_done = 1'b0;

  assign bus.dp_done = auto_done | force_done;

  // Pulse counters and captures, all sampled on the falling edge
  always @(negedge clk) begin
    if (bus.command_rd_en) rd_cnt++;
    if (bus.dp_start) begin
      start_cnt++;
      start_op   = bus.dp_op;
      start_a    = bus.dp_a;
      start_b    = bus.dp_b;
      start_dpop = bus.data_pop;
    end
    if (bus.status_wr_en) begin
      wr_cnt++;
      last_status = bus.status_out;
    end
    if (bus.done_out) done_cnt++;
    if (bus.busy) busy_cnt++;
  end

  // Command FIFO model: token appears the cycle after the pop and is junk otherwise
  always @(negedge clk) begin
    if (bus.command_rd_en) begin
      bus.command_in = pending_cmd;
      cmd_hold = 1'b1;
    end else if (cmd_hold) begin
      cmd_hold = 1'b0;
    end else begin
      bus.command_in = 16'hDEAD;
    end
  end

  // Datapath model: completes dp_lat+1 cycles after the start pulse
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (dp_cd == 0) begin
      auto_done = dp_auto;
      dp_cd = -1;
    end else if (dp_cd > 0) begin
      dp_cd = dp_cd - 1;
    end
    if (bus.dp_start) dp_cd = dp_lat;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int model_code(input logic [15:0] cmd, input logic [3:0] ni,
                                    input int dpop, input int rfs);
    int op, b;
    bit ready;
    op = int'(cmd[15:8]);
    b  = int'(cmd[4:0]);
    if (op < 1 || op > 5) return 1;
    if (op >= 2 && op <= 4 && ni == 4'hF) return 2;
    if ((op == 1 && b > 10) || (op == 3 && b == 0)) return 3;
    case (op)
      1: ready = dpop >= b + 1;
      2: ready = dpop >= 1 && rfs >= 1;
      3: ready = dpop >= b && rfs >= b;
      4: ready = rfs >= int'(ni) + 1;
      default: ready = 1'b1;
    endcase
    return ready ? 0 : 4;
  endfunction

  function automatic int model_busy(input int code, input int lat);
    int chk;
    chk = (code == 4) ? WL : 1;
    return 4 + chk + ((code == 0) ? lat + 2 : 0);
  endfunction

  task automatic snap();
    s_rd = rd_cnt; s_start = start_cnt; s_wr = wr_cnt; s_done = done_cnt; s_busy = busy_cnt;
  endtask

  task automatic delta();
    d_rd = rd_cnt - s_rd; d_start = start_cnt - s_start; d_wr = wr_cnt - s_wr;
    d_done = done_cnt - s_done; d_busy = busy_cnt - s_busy;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > s_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fire(input logic [15:0] cmd, input logic [3:0] ni, input logic [PW-1:0] dpop,
                      input logic [PW-1:0] rfs, input int lat, output bit ok);
    @(negedge clk);
    pending_cmd = cmd;
    bus.ni_in = ni;
    bus.data_pop = dpop;
    bus.result_free_space = rfs;
    bus.command_pop = 10'd3;
    bus.status_free_space = 10'd7;
    dp_lat = lat;
    dp_auto = 1'b1;
    snap();
    bus.invoke = 1'b1;
    @(negedge clk);
    bus.invoke = 1'b0;
    wait_done(300, ok);
    repeat (2) @(negedge clk);
    delta();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.invoke = 1'b0;
    bus.command_pop = '0;
    bus.data_pop = '0;
    bus.result_free_space = '0;
    bus.status_free_space = '0;
    bus.ni_in = 4'h0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.status_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000000", bus.status_out); end
    checks++; if ({bus.dp_start, bus.command_rd_en, bus.status_wr_en, bus.done_out} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {bus.dp_start, bus.command_rd_en, bus.status_wr_en, bus.done_out}); end
    checks++; if ({bus.dp_op, bus.dp_a, bus.dp_b} !== 11'h0) begin errors++; $display("[TB] FAIL reset_args: got %h expected 000", {bus.dp_op, bus.dp_a, bus.dp_b}); end
    checks++; if (bus.enable_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %b expected 0", bus.enable_out); end
    rst = 1'b0;
    bus.command_pop = 10'd1;
    bus.status_free_space = 10'd1;
    #1;
    checks++; if (bus.enable_out !== 1'b1) begin errors++; $display("[TB] FAIL enable_comb: got %b expected 1", bus.enable_out); end
    bus.status_free_space = 10'd0;
    #1;
    checks++; if (bus.enable_out !== 1'b0) begin errors++; $display("[TB] FAIL enable_no_status_space: got %b expected 0", bus.enable_out); end
  endtask

  task automatic test_rst_command();
    bit ok;
    fire(16'h0500, 4'h0, 10'd1, 10'd1, 2, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rstcmd_done: got timeout expected done_out"); end
    checks++; if (d_rd !== 1) begin errors++; $display("[TB] FAIL rstcmd_rd_en: got %0d expected 1", d_rd); end
    checks++; if (d_start !== 1 || start_op !== 3'd5) begin errors++; $display("[TB] FAIL rstcmd_start: got %0d op %0d expected 1 op 5", d_start, start_op); end
    checks++; if (last_status !== 32'h0500_0000 || d_wr !== 1) begin errors++; $display("[TB] FAIL rstcmd_status: got %h x%0d expected 05000000 x1", last_status, d_wr); end
    checks++; if (d_busy !== 9) begin errors++; $display("[TB] FAIL rstcmd_latency: got %0d expected 9", d_busy); end
    checks++; if (bus.status_out !== 32'h0500_0000) begin errors++; $display("[TB] FAIL status_hold: got %h expected 05000000", bus.status_out); end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    fire(16'h0900, 4'h0, 10'd5, 10'd5, 0, ok);
    checks++; if (!ok || d_done !== 1) begin errors++; $display("[TB] FAIL badop_done: got %0d expected 1", d_done); end
    checks++; if (d_start !== 0) begin errors++; $display("[TB] FAIL badop_start: got %0d expected 0", d_start); end
    checks++; if (last_status !== 32'h0900_0001) begin errors++; $display("[TB] FAIL badop_status: got %h expected 09000001", last_status); end
  endtask

  task automatic test_evb_wait();
    bit ok;
    @(negedge clk);
    pending_cmd = 16'h0344;
    bus.ni_in = 4'd3;
    bus.result_free_space = 10'd8;
    bus.data_pop = 10'd2;
    bus.command_pop = 10'd1;
    bus.status_free_space = 10'd1;
    dp_lat = 1;
    dp_auto = 1'b1;
    snap();
    bus.invoke = 1'b1;
    @(negedge clk);
    bus.invoke = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (start_cnt !== s_start) begin errors++; $display("[TB] FAIL evb_early_start: got %0d expected 0", start_cnt - s_start); end
    bus.data_pop = 10'd4;
    wait_done(300, ok);
    repeat (2) @(negedge clk);
    delta();
    checks++; if (!ok || d_start !== 1 || start_dpop !== 10'd4) begin errors++; $display("[TB] FAIL evb_start: got %0d pop %0d expected 1 pop 4", d_start, start_dpop); end
    checks++; if ({start_a, start_b} !== {3'd2, 5'd4}) begin errors++; $display("[TB] FAIL evb_args: got %0d/%0d expected 2/4", start_a, start_b); end
    checks++; if (last_status !== 32'h0344_0000) begin errors++; $display("[TB] FAIL evb_status: got %h expected 03440000", last_status); end
    checks++; if (d_busy !== 12) begin errors++; $display("[TB] FAIL evb_latency: got %0d expected 12", d_busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    fire(16'h0220, 4'h1, 10'd0, 10'd5, 0, ok);
    checks++; if (!ok || d_start !== 0) begin errors++; $display("[TB] FAIL timeout_start: got %0d expected 0", d_start); end
    checks++; if (d_busy !== 4 + WL) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", d_busy, 4 + WL); end
    checks++; if (last_status !== 32'h0220_0004) begin errors++; $display("[TB] FAIL timeout_status: got %h expected 02200004", last_status); end
  endtask

  task automatic test_errors();
    bit ok;
    fire(16'h0220, 4'hF, 10'd5, 10'd5, 0, ok);
    checks++; if (!ok || d_start !== 0 || last_status !== 32'h0220_0002) begin errors++; $display("[TB] FAIL err_ni: got %h start %0d expected 02200002 start 0", last_status, d_start); end
    fire(16'h012B, 4'h0, 10'd30, 10'd5, 0, ok);
    checks++; if (!ok || d_start !== 0 || last_status !== 32'h012B_0003) begin errors++; $display("[TB] FAIL err_stp_b: got %h start %0d expected 012B0003 start 0", last_status, d_start); end
    fire(16'h010A, 4'h0, 10'd11, 10'd0, 0, ok);
    checks++; if (!ok || d_start !== 1 || last_status !== 32'h010A_0000) begin errors++; $display("[TB] FAIL stp_b10: got %h start %0d expected 010A0000 start 1", last_status, d_start); end
    fire(16'h0340, 4'h2, 10'd5, 10'd5, 0, ok);
    checks++; if (!ok || d_start !== 0 || last_status !== 32'h0340_0003) begin errors++; $display("[TB] FAIL err_evb_b0: got %h start %0d expected 03400003 start 0", last_status, d_start); end
  endtask

  task automatic test_ignored_invoke();
    @(negedge clk);
    bus.command_pop = 10'd0;
    bus.status_free_space = 10'd4;
    snap();
    bus.invoke = 1'b1;
    repeat (3) @(negedge clk);
    bus.command_pop = 10'd4;
    bus.status_free_space = 10'd0;
    repeat (3) @(negedge clk);
    bus.invoke = 1'b0;
    repeat (2) @(negedge clk);
    delta();
    checks++; if (d_rd !== 0 || d_busy !== 0 || d_done !== 0) begin errors++; $display("[TB] FAIL ignored_invoke: got rd %0d busy %0d done %0d expected 0 0 0", d_rd, d_busy, d_done); end
  endtask

  task automatic test_random();
    logic [7:0] ops [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h03, 8'h04, 8'h81};
    logic [15:0] cmd;
    logic [3:0]  ni;
    int dpop, rfs, lat, code;
    bit ok;
    for (int it = 0; it < 40; it++) begin
      cmd = {ops[$urandom_range(0, 9)], 8'($urandom_range(0, 255))};
      ni  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dpop = $urandom_range(0, 24);
      rfs  = $urandom_range(0, 16);
      lat  = $urandom_range(0, 3);
      code = model_code(cmd, ni, dpop, rfs);
      fire(cmd, ni, PW'(dpop), PW'(rfs), lat, ok);
      checks++; if (!ok || d_wr !== 1 || last_status !== {cmd, 8'h00, 8'(code)}) begin
        errors++; $display("[TB] FAIL rand_status[%0d]: got %h x%0d expected %h", it, last_status, d_wr, {cmd, 8'h00, 8'(code)}); end
      checks++; if (d_start !== ((code == 0) ? 1 : 0)) begin
        errors++; $display("[TB] FAIL rand_start[%0d]: got %0d expected %0d", it, d_start, (code == 0) ? 1 : 0); end
      if (code == 0) begin
        checks++; if ({start_op, start_a, start_b} !== cmd[10:0]) begin
          errors++; $display("[TB] FAIL rand_args[%0d]: got %h expected %h", it, {start_op, start_a, start_b}, cmd[10:0]); end
      end
      checks++; if (d_busy !== model_busy(code, lat)) begin
        errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", it, d_busy, model_busy(code, lat)); end
    end
  endtask

  task automatic test_reset_mid_firing();
    @(negedge clk);
    pending_cmd = 16'h0221;
    bus.ni_in = 4'd2;
    bus.data_pop = 10'd3;
    bus.result_free_space = 10'd3;
    bus.command_pop = 10'd2;
    bus.status_free_space = 10'd2;
    dp_auto = 1'b0;
    snap();
    bus.invoke = 1'b1;
    @(negedge clk);
    bus.invoke = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || start_cnt - s_start !== 1) begin errors++; $display("[TB] FAIL midrst_in_busy: got busy %b starts %0d expected 1 1", bus.busy, start_cnt - s_start); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.status_out !== 32'h0 || {bus.dp_op, bus.dp_a, bus.dp_b} !== 11'h0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got busy %b status %h args %h expected 0 0 0", bus.busy, bus.status_out, {bus.dp_op, bus.dp_a, bus.dp_b}); end
    @(negedge clk);
    rst = 1'b0;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (4) @(negedge clk);
    delta();
    checks++; if (d_wr !== 0 || d_done !== 0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_late_done: got wr %0d done %0d busy %b expected 0 0 0", d_wr, d_done, bus.busy); end
    dp_auto = 1'b1;
  endtask

  initial begin
    $display("[TB] starting pea_command_scheduler bench");
    test_reset();
    test_rst_command();
    test_bad_opcode();
    test_evb_wait();
    test_timeout();
    test_errors();
    test_ignored_invoke();
    test_random();
    test_reset_mid_firing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
